usb_fifo_arbiter: RTL and testbench

- Shares the single FT245-style USB FIFO bus (RXF_N/TXE_N in; RD_N/WR/data out) between two bus masters.
- Master 0 is the USB FIFO state machine for the endpoint path. Master 1 is the UART transfer bridge.
- Sits between both masters and the FTDI pins. Only the granted master's strobes and data-drive enable reach the pins.
- Round-robin grant, with a byte-quota preemption rule and a bus turnaround gap between owners.

---
 rtl/usb_fifo_arbiter_if.sv | 30 +++
 rtl/usb_fifo_arbiter.sv | 162 ++++++++++++++++
 tb/tb_usb_fifo_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_fifo_arbiter_if.sv
// Bus bundle between the FIFO arbiter, its two masters and the FT245 pins.
// The slave side is the arbiter; the master side is everything around it.
interface usb_fifo_arbiter_if #(
    parameter int NUM_M = 2
);
    logic             usb_rxf_n;
    logic             usb_txe_n;
    logic             usb_rd_n;
    logic             usb_wr;
    logic             usb_data_oe;
    logic [NUM_M-1:0] m_req;
    logic [NUM_M-1:0] m_rd_n;
    logic [NUM_M-1:0] m_wr;
    logic [NUM_M-1:0] m_oe;
    logic [NUM_M-1:0] m_gnt;
    logic [NUM_M-1:0] m_rxf_n;
    logic [NUM_M-1:0] m_txe_n;
    logic             busy;
    logic             gnt_id;

    modport slave (
        input  usb_rxf_n, usb_txe_n, m_req, m_rd_n, m_wr, m_oe,
        output usb_rd_n, usb_wr, usb_data_oe, m_gnt, m_rxf_n, m_txe_n, busy, gnt_id
    );

    modport master (
        output usb_rxf_n, usb_txe_n, m_req, m_rd_n, m_wr, m_oe,
        input  usb_rd_n, usb_wr, usb_data_oe, m_gnt, m_rxf_n, m_txe_n, busy, gnt_id
    );
endinterface

// File: rtl/usb_fifo_arbiter.sv
// Two-master round-robin arbiter for a shared FT245 FIFO bus, with a
// per-grant byte quota and a fixed idle turnaround between owners.

// Per-master strobe tracker: flags a completed byte and a quiet bus.
module usb_fifo_arb_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic rd_n,
    input  logic wr,
    input  logic oe,
    input  logic en,
    output logic byte_done,
    output logic quiet
);
    logic rd_n_q;
    logic wr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_n_q <= 1'b1;
            wr_q   <= 1'b0;
        end else begin
            rd_n_q <= rd_n;
            wr_q   <= wr;
        end
    end

    // A read completes on RD_N rising, a write on WR falling.
    assign byte_done = en & ((rd_n & ~rd_n_q) | (~wr & wr_q));
    assign quiet     = rd_n & ~wr & ~oe;
endmodule

module usb_fifo_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int TURN_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    usb_fifo_arbiter_if.slave  bus
);
    localparam int NUM_M = 2;
    localparam logic [7:0] HOLD  = 8'(HOLD_MAX);
    localparam logic [3:0] TLOAD = 4'(TURN_CYC - 1);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    state_t           state;
    logic             own;
    logic             pri;
    logic [7:0]       cnt;
    logic [3:0]       tcnt;
    logic [NUM_M-1:0] gnt_q;
    logic [NUM_M-1:0] rxf_q;
    logic [NUM_M-1:0] txe_q;
    logic             rd_n_q;
    logic             wr_q;
    logic             oe_q;
    logic             busy_q;

    logic [NUM_M-1:0] byte_done;
    logic [NUM_M-1:0] quiet;
    logic             in_grant;
    logic             pick;
    logic             quota_hit;
    logic             release_go;

    assign in_grant = (state == GRANT);

    for (genvar i = 0; i < NUM_M; i++) begin : g_lane
        usb_fifo_arb_lane u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .rd_n      (bus.m_rd_n[i]),
            .wr        (bus.m_wr[i]),
            .oe        (bus.m_oe[i]),
            .en        (in_grant && (own == 1'(i))),
            .byte_done (byte_done[i]),
            .quiet     (quiet[i])
        );
    end

    // Contention goes to PRI; a lone requester wins regardless.
    assign pick       = (&bus.m_req) ? pri : bus.m_req[1];
    assign quota_hit  = (cnt >= HOLD) && bus.m_req[~own];
    assign release_go = in_grant && quiet[own] && (!bus.m_req[own] || quota_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            own    <= 1'b0;
            pri    <= 1'b0;
            cnt    <= 8'd0;
            tcnt   <= 4'd0;
            gnt_q  <= '0;
            rxf_q  <= '1;
            txe_q  <= '1;
            rd_n_q <= 1'b1;
            wr_q   <= 1'b0;
            oe_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            rxf_q  <= '1;
            txe_q  <= '1;
            rd_n_q <= 1'b1;
            wr_q   <= 1'b0;
            oe_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.m_req) begin
                        state  <= GRANT;
                        own    <= pick;
                        gnt_q  <= pick ? 2'b10 : 2'b01;
                        cnt    <= 8'd0;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                GRANT: begin
                    busy_q <= 1'b1;
                    if (release_go) begin
                        state <= TURN;
                        gnt_q <= '0;
                        pri   <= ~own;
                        tcnt  <= TLOAD;
                    end else begin
                        if (byte_done[own] && (cnt < HOLD))
                            cnt <= cnt + 8'd1;
                        rd_n_q     <= bus.m_rd_n[own];
                        wr_q       <= bus.m_wr[own];
                        oe_q       <= bus.m_oe[own];
                        rxf_q[own] <= bus.usb_rxf_n;
                        txe_q[own] <= bus.usb_txe_n;
                    end
                end
                TURN: begin
                    if (tcnt == 4'd0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        tcnt   <= tcnt - 4'd1;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.m_gnt       = gnt_q;
    assign bus.gnt_id      = own;
    assign bus.busy        = busy_q;
    assign bus.m_rxf_n     = rxf_q;
    assign bus.m_txe_n     = txe_q;
    assign bus.usb_rd_n    = rd_n_q;
    assign bus.usb_wr      = wr_q;
    assign bus.usb_data_oe = oe_q;
endmodule

// File: tb/tb_usb_fifo_arbiter.sv
// Scoreboard bench for usb_fifo_arbiter: directed master traffic pushes
// expected grants and pin pulses; a negedge monitor pops and compares.
module tb_usb_fifo_arbiter;
    localparam int HOLD_MAX = 16;
    localparam int TURN_CYC = 2;

    typedef struct {
        logic [1:0] gnt;
        int         gap;
    } gnt_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rxf_pin = 1'b0;
    logic txe_pin = 1'b0;
    logic m0_req = 1'b0, m0_rd_n = 1'b1, m0_wr = 1'b0, m0_oe = 1'b0;
    logic m1_req = 1'b0, m1_rd_n = 1'b1, m1_wr = 1'b0, m1_oe = 1'b0;

    int vec_cnt = 0;
    int err_cnt = 0;

    gnt_exp_t exp_gnt[$];
    int       exp_rd[$];
    int       exp_wr[$];

    usb_fifo_arbiter_if bus ();

    assign bus.usb_rxf_n = rxf_pin;
    assign bus.usb_txe_n = txe_pin;
    assign bus.m_req     = {m1_req, m0_req};
    assign bus.m_rd_n    = {m1_rd_n, m0_rd_n};
    assign bus.m_wr      = {m1_wr, m0_wr};
    assign bus.m_oe      = {m1_oe, m0_oe};

    usb_fifo_arbiter #(.HOLD_MAX(HOLD_MAX), .TURN_CYC(TURN_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic req, input logic rd_n, input logic wr, input logic oe);
        if (m == 0) begin
            m0_req = req; m0_rd_n = rd_n; m0_wr = wr; m0_oe = oe;
        end else begin
            m1_req = req; m1_rd_n = rd_n; m1_wr = wr; m1_oe = oe;
        end
    endtask

    task automatic wait_gnt(input int m);
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.m_gnt[m]) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk($sformatf("gnt_timeout_m%0d", m), 0, 1);
    endtask

    task automatic master_read(input int m, input int n, input int low);
        for (int b = 0; b < n; b++) begin
            set_m(m, 1'b1, 1'b0, 1'b0, 1'b0);
            repeat (low) tick();
            set_m(m, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
    endtask

    // One byte = drive+strobe, strobe low, bus released; stops once ungranted.
    task automatic master_write(input int m, input int n, output int done);
        done = 0;
        for (int b = 0; b < n; b++) begin
            if (!bus.m_gnt[m]) break;
            set_m(m, 1'b1, 1'b1, 1'b1, 1'b1);
            tick();
            set_m(m, 1'b1, 1'b1, 1'b0, 1'b1);
            tick();
            set_m(m, 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
            done++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- monitor ----------------
    logic [1:0] prev_gnt = 2'b00;
    logic [2:0] prev_str = 3'b100;
    logic [1:0] prev_usb = 2'b11;
    int         rd_run = 0;
    int         wr_run = 0;
    int         gap = 0;
    int         gap_busy = 0;

    always @(negedge clk) begin
        logic       keep;
        logic [2:0] exp_pins;
        logic [3:0] exp_gate;
        gnt_exp_t   e;
        int         ln;
        if (!rst_n) begin
            prev_gnt = 2'b00;
            prev_str = 3'b100;
            rd_run   = 0;
            wr_run   = 0;
            gap      = 0;
            gap_busy = 0;
        end else begin
            keep     = (prev_gnt != 2'b00) && (bus.m_gnt == prev_gnt);
            exp_pins = keep ? prev_str : 3'b100;
            exp_gate = 4'b1111;
            if (keep) begin
                exp_gate[{1'b1, prev_gnt[1]}] = prev_usb[1];
                exp_gate[{1'b0, prev_gnt[1]}] = prev_usb[0];
            end
            chk("pin_mux", {bus.usb_rd_n, bus.usb_wr, bus.usb_data_oe}, exp_pins);
            chk("flag_gate", {bus.m_rxf_n, bus.m_txe_n}, exp_gate);
            if (bus.m_gnt == 2'b11) chk("gnt_onehot", bus.m_gnt, 2'b01);

            if (prev_gnt == 2'b00 && bus.m_gnt != 2'b00) begin
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_gnt", bus.m_gnt, 2'b00);
                end else begin
                    e = exp_gnt.pop_front();
                    chk("gnt_order", bus.m_gnt, e.gnt);
                    chk("gnt_id", bus.gnt_id, e.gnt[1]);
                    if (e.gap >= 0) begin
                        chk("turn_gap", gap, e.gap);
                        chk("turn_busy", gap_busy, TURN_CYC);
                    end
                end
            end
            if (bus.m_gnt == 2'b00) begin
                gap++;
                if (bus.busy) gap_busy++;
            end else begin
                gap = 0;
                gap_busy = 0;
            end

            if (!bus.usb_rd_n) rd_run++;
            else if (rd_run > 0) begin
                ln = (exp_rd.size() > 0) ? exp_rd.pop_front() : -1;
                chk("rd_pulse_len", rd_run, ln);
                rd_run = 0;
            end
            if (bus.usb_wr) wr_run++;
            else if (wr_run > 0) begin
                ln = (exp_wr.size() > 0) ? exp_wr.pop_front() : -1;
                chk("wr_pulse_len", wr_run, ln);
                wr_run = 0;
            end

            prev_gnt = bus.m_gnt;
            prev_str = {bus.m_rd_n[bus.m_gnt[1]], bus.m_wr[bus.m_gnt[1]], bus.m_oe[bus.m_gnt[1]]};
            prev_usb = {bus.usb_rxf_n, bus.usb_txe_n};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int done;
        // Reset with all master strobes asserted: pins must stay idle.
        m0_rd_n = 1'b0; m1_rd_n = 1'b0; m0_wr = 1'b1; m1_wr = 1'b1; m0_oe = 1'b1; m1_oe = 1'b1;
        tick();
        tick();
        chk("rst_pins", {bus.usb_rd_n, bus.usb_wr, bus.usb_data_oe}, 3'b100);
        chk("rst_gnt", bus.m_gnt, 2'b00);
        chk("rst_flags", {bus.m_rxf_n, bus.m_txe_n}, 4'b1111);
        chk("rst_busy_id", {bus.busy, bus.gnt_id}, 2'b00);
        set_m(0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_m(1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Single master 1, three reads.
        exp_gnt.push_back('{2'b10, -1});
        repeat (3) exp_rd.push_back(1);
        set_m(1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("gnt_latency", bus.m_gnt, 2'b10);
        master_read(1, 3, 1);
        set_m(1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) tick();
        chk("single_idle", {bus.busy, bus.m_gnt}, 3'b000);

        // Contention from reset: master 0 first, then master 1 after the gap.
        do_reset();
        exp_gnt.push_back('{2'b01, -1});
        exp_gnt.push_back('{2'b10, TURN_CYC + 1});
        exp_rd.push_back(2); exp_rd.push_back(2); exp_rd.push_back(3);
        fork
            begin
                set_m(0, 1'b1, 1'b1, 1'b0, 1'b0);
                wait_gnt(0);
                master_read(0, 2, 2);
                set_m(0, 1'b0, 1'b1, 1'b0, 1'b0);
            end
            begin
                set_m(1, 1'b1, 1'b1, 1'b0, 1'b0);
                wait_gnt(1);
                master_read(1, 1, 3);
                set_m(1, 1'b0, 1'b1, 1'b0, 1'b0);
            end
        join
        repeat (6) tick();

        // Quota: master 0 streams writes and is preempted after HOLD_MAX bytes.
        exp_gnt.push_back('{2'b01, -1});
        exp_gnt.push_back('{2'b10, TURN_CYC + 1});
        repeat (HOLD_MAX) exp_wr.push_back(1);
        exp_rd.push_back(1);
        fork
            begin
                set_m(0, 1'b1, 1'b1, 1'b0, 1'b0);
                wait_gnt(0);
                master_write(0, 20, done);
                set_m(0, 1'b0, 1'b1, 1'b0, 1'b0);
                chk("quota_bytes", done, HOLD_MAX);
            end
            begin
                set_m(1, 1'b1, 1'b1, 1'b0, 1'b0);
                wait_gnt(1);
                master_read(1, 1, 1);
                set_m(1, 1'b0, 1'b1, 1'b0, 1'b0);
            end
        join
        repeat (6) tick();

        // Quiet-bus hold: REQ drops while RD_N is low for 4 cycles.
        exp_gnt.push_back('{2'b01, -1});
        exp_rd.push_back(4);
        set_m(0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_gnt(0);
        set_m(0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_gnt", bus.m_gnt, 2'b01);
        end
        set_m(0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("release_after_quiet", bus.m_gnt, 2'b00);
        repeat (6) tick();

        // Asynchronous reset in the middle of a master 1 write.
        exp_gnt.push_back('{2'b10, -1});
        set_m(1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_gnt(1);
        set_m(1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        chk("wr_before_rst", {bus.usb_wr, bus.usb_data_oe}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pins", {bus.usb_rd_n, bus.usb_wr, bus.usb_data_oe}, 3'b100);
        chk("async_rst_state", {bus.busy, bus.m_gnt, bus.gnt_id}, 4'b0000);
        chk("async_rst_flags", {bus.m_rxf_n, bus.m_txe_n}, 4'b1111);
        set_m(1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        exp_gnt.push_back('{2'b01, -1});
        exp_gnt.push_back('{2'b10, TURN_CYC + 1});
        set_m(0, 1'b1, 1'b1, 1'b0, 1'b0);
        set_m(1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("post_rst_gnt", bus.m_gnt, 2'b01);
        set_m(0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_gnt(1);
        set_m(1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) tick();

        chk("gnt_queue_empty", exp_gnt.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        chk("wr_queue_empty", exp_wr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
